// File: rtl/tick_rate_scheduler.sv
// -----------------------------------------------------------------------------
// tick_rate_scheduler
//
// Central tick generator for the Basys 3 calculator. A shared prescaler
// divides the 100 MHz board clock into a base tick, and NUM_CH per-channel
// counters turn base ticks into one-cycle clock-enable pulses at individually
// programmable rates. Everything runs in the clock_100MHz domain.
//
// A channel with period N ticks once every N+1 base ticks. New periods arrive
// over a valid/ready port, are held in a shadow register and applied at the
// channel's next terminal count (or on the next cycle if the channel is
// disabled), so a running channel never sees a truncated period.
//
// Optional build macro: TICK_CFG_IMMEDIATE_EN
//   When defined, an accepted period is written straight into the channel,
//   its counter restarts from 0, pending stays 0 and cfg_ready stays 1.
//
// Ports:
//   clock_100MHz  in   board clock, sole clock
//   reset         in   asynchronous, active-high reset
//   cfg_valid     in   configuration request
//   cfg_ready     out  scheduler can accept a configuration request
//   cfg_chan      in   target channel (out-of-range requests are discarded)
//   cfg_value     in   new period value
//   ch_enable     in   per-channel run enable
//   base_tick     out  one-cycle pulse every PRESCALE cycles
//   tick          out  one-cycle pulse per channel at its terminal count
//   pending       out  channel holds an accepted, not-yet-applied period
// -----------------------------------------------------------------------------
module tick_rate_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int PRESCALE       = 100,
  parameter int CNT_W          = 20,
  parameter int DEFAULT_PERIOD = 999
) (
  input  logic                      clock_100MHz,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_chan,
  input  logic [CNT_W-1:0]          cfg_value,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic                      base_tick,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pending
);

  localparam int                CH_W         = $clog2(NUM_CH);
  localparam int                PRE_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);

`ifdef TICK_CFG_IMMEDIATE_EN
  localparam bit IMMEDIATE = 1'b1;
`else
  localparam bit IMMEDIATE = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    WAIT_APPLY
  } cfg_state_t;

  cfg_state_t        state, state_next;
  logic [CH_W-1:0]   target;
  logic              chan_ok;
  logic              accept;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] term;
  logic [PRE_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  period [NUM_CH];

  // ---------------------------------------------------------------------------
  // Prescaler: base_tick is registered, so the first pulse appears PRESCALE
  // cycles after reset release.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clock_100MHz or posedge reset) begin
    if (reset) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt   <= '0;
      base_tick <= 1'b1;
    end else begin
      pre_cnt   <= pre_cnt + 1'b1;
      base_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration handshake
  // ---------------------------------------------------------------------------
  assign chan_ok = int'(cfg_chan) < NUM_CH;
  assign accept  = cfg_valid && (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && chan_ok && !IMMEDIATE) state_next = WAIT_APPLY;
      end
      WAIT_APPLY: begin
        // Watch the registered pending bit: ready returns the cycle after it
        // is seen clear.
        if (!pending[target]) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_100MHz or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      target <= '0;
    end else begin
      state <= state_next;
      if (accept && chan_ok) target <= cfg_chan;
    end
  end

  always_comb begin
    wr_sel = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = accept && chan_ok && (int'(cfg_chan) == i);
      // Terminal count: the counter acts on the cycle base_tick is high.
      term[i]   = base_tick && ch_enable[i] && (cnt[i] == period[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Period update path
  // ---------------------------------------------------------------------------
`ifndef TICK_CFG_IMMEDIATE_EN
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] apply;

  // A disabled channel has no terminal count to wait for, so it takes the
  // shadow value straight away.
  assign apply   = pend_q & (term | ~ch_enable);
  assign pending = pend_q;

  always_ff @(posedge clock_100MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Only one update is outstanding, so a write never meets an apply on
        // the same channel; a write landing on a terminal waits for the next.
        if (wr_sel[i]) begin
          shadow[i] <= cfg_value;
          pend_q[i] <= 1'b1;
        end else if (apply[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign pending = '0;
`endif

  // ---------------------------------------------------------------------------
  // Channel counters (compare-and-reset: period N -> tick every N+1 base ticks)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_100MHz or posedge reset) begin
    if (reset) begin
      // NOTE: the period array is a handful of flops whose reset value is
      // architecturally visible, so it is reset like any other register.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        period[i] <= RESET_PERIOD;
      end
      tick <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tick[i] <= term[i];
        if (!ch_enable[i] || term[i]) begin
          cnt[i] <= '0;
        end else if (base_tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
`ifdef TICK_CFG_IMMEDIATE_EN
        // Restart on the new period; the interrupted period gives no tick.
        if (wr_sel[i]) begin
          period[i] <= cfg_value;
          cnt[i]    <= '0;
          tick[i]   <= 1'b0;
        end
`else
        if (apply[i]) period[i] <= shadow[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_tick_rate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_rate_scheduler
//
// Self-checking bench for tick_rate_scheduler (PRESCALE=4, DEFAULT_PERIOD=2).
// A reference model counts down base ticks per channel and pushes the
// expected outputs for every cycle into a scoreboard queue; a monitor pops and
// compares on the falling edge. Directed timing checks and a NUM_CH=3
// instance cover the out-of-range channel case.
// -----------------------------------------------------------------------------
module tb_tick_rate_scheduler;

  localparam int NCH  = 4;
  localparam int PRE  = 4;
  localparam int CW   = 8;
  localparam int DEFP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_chan;
  logic [CW-1:0]  cfg_value;
  logic [NCH-1:0] ch_en;
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  logic           c3_valid;
  logic           ready3;
  logic [1:0]     c3_chan;
  logic [CW-1:0]  c3_value;
  logic [2:0]     c3_en;
  logic           base3;
  logic [2:0]     tick3;
  logic [2:0]     pend3;

  always #5 clk = ~clk;

  tick_rate_scheduler #(
    .NUM_CH(NCH), .PRESCALE(PRE), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)
  ) u_dut (
    .clock_100MHz(clk), .reset(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_value(cfg_value),
    .ch_enable(ch_en), .base_tick(base_tick),
    .tick(tick), .pending(pending)
  );

  tick_rate_scheduler #(
    .NUM_CH(3), .PRESCALE(PRE), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)
  ) u_dut3 (
    .clock_100MHz(clk), .reset(rst),
    .cfg_valid(c3_valid), .cfg_ready(ready3),
    .cfg_chan(c3_chan), .cfg_value(c3_value),
    .ch_enable(c3_en), .base_tick(base3),
    .tick(tick3), .pending(pend3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each channel waits (period+1) base ticks per tick.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic           base;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;
    logic           ready;
  } exp_t;

  exp_t           sb[$];
  int             m_t;
  logic           m_base;
  logic           m_ready;
  int             m_tgt;
  int             m_rem  [NCH];
  int             m_per  [NCH];
  int             m_shad [NCH];
  logic [NCH-1:0] m_pend;

  task automatic model_reset();
    m_t     = 0;
    m_base  = 1'b0;
    m_ready = 1'b1;
    m_tgt   = 0;
    m_pend  = '0;
    for (int i = 0; i < NCH; i++) begin
      m_per[i]  = DEFP;
      m_rem[i]  = DEFP + 1;
      m_shad[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] pend_old;
    logic [NCH-1:0] tk;
    logic           acc;
    exp_t           e;
    pend_old = m_pend;
    tk       = '0;
    acc      = cfg_valid && m_ready;
    for (int i = 0; i < NCH; i++) begin
      if (!ch_en[i]) begin
        if (m_pend[i]) begin
          m_per[i]  = m_shad[i];
          m_pend[i] = 1'b0;
        end
        m_rem[i] = m_per[i] + 1;
      end else if (m_base) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          tk[i] = 1'b1;
          if (m_pend[i]) begin
            m_per[i]  = m_shad[i];
            m_pend[i] = 1'b0;
          end
          m_rem[i] = m_per[i] + 1;
        end
      end
    end
    if (acc) begin
      m_shad[int'(cfg_chan)] = int'(cfg_value);
      m_pend[int'(cfg_chan)] = 1'b1;
    end
    if (m_ready) begin
      if (acc) begin
        m_ready = 1'b0;
        m_tgt   = int'(cfg_chan);
      end
    end else if (!pend_old[m_tgt]) begin
      m_ready = 1'b1;
    end
    m_t++;
    m_base  = (m_t % PRE) == 0;
    e.base  = m_base;
    e.tick  = tk;
    e.pend  = m_pend;
    e.ready = m_ready;
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst === 1'b0) model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst === 1'b0 && sb.size() > 0) begin
      e = sb.pop_front();
      n_popped++;
      check("sb_base_tick", base_tick, e.base);
      check("sb_tick",      tick,      e.tick);
      check("sb_pending",   pending,   e.pend);
      check("sb_cfg_ready", cfg_ready, e.ready);
    end
  end

  // ---------------------------------------------------------------------------
  // NUM_CH=3 instance: out-of-range channel is accepted and discarded.
  // ---------------------------------------------------------------------------
  initial begin
    c3_valid = 1'b0;
    c3_chan  = '0;
    c3_value = '0;
    c3_en    = 3'b111;
    wait (rst === 1'b1);
    @(negedge rst);
    c3_valid = 1'b1;
    c3_chan  = 2'd3;
    c3_value = 8'd9;
    @(negedge clk);
    c3_valid = 1'b0;
    check("d3_oob_ready",   ready3, 1);
    check("d3_oob_pending", pend3,  0);
    repeat (11) @(negedge clk);
    check("d3_base_c12",    base3,  1);
    @(negedge clk);
    check("d3_tick_default", tick3, 3'b111);
    check("d3_ready_still",  ready3, 1);
    c3_valid = 1'b1;
    c3_chan  = 2'd2;
    c3_value = 8'd1;
    @(negedge clk);
    c3_valid = 1'b0;
    check("d3_inrange_pending", pend3,  3'b100);
    check("d3_inrange_ready",   ready3, 0);
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  int n;
  int nb;
  int cnt_hi;

  task automatic cycles_to_tick(input int ch, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick[ch] && cyc < limit);
  endtask

  initial begin
    model_reset();
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_value = '0;
    ch_en     = 4'hF;
    #1 rst = 1'b1;
    #2;
    check("rst_base_tick", base_tick, 0);
    check("rst_tick",      tick,      0);
    check("rst_pending",   pending,   0);
    check("rst_cfg_ready", cfg_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Power-up timing: base_tick at cycle 4, first ticks at cycle 13.
    n = 0;
    do begin @(negedge clk); n++; end while (!base_tick && n < 20);
    check("first_base_cycle", n, 4);
    do begin @(negedge clk); n++; end while (!tick[0] && n < 40);
    check("first_tick_cycle", n, 13);
    check("first_tick_all", tick, 4'hF);
    cycles_to_tick(0, 40, n);
    check("tick0_spacing", n, 12);

    // Channel 1 -> period 0, written mid-period.
    repeat (5) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd1;
    cfg_value = 8'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("wr1_pending", pending, 4'b0010);
    check("wr1_ready",   cfg_ready, 0);
    n = 0;
    while (pending[1] && n < 60) begin @(negedge clk); n++; end
    check("wr1_applied", pending[1], 0);
    check("wr1_tick_at_apply", tick[1], 1);
    cycles_to_tick(1, 20, n);
    check("tick1_fast_a", n, 4);
    cycles_to_tick(1, 20, n);
    check("tick1_fast_b", n, 4);
    cycles_to_tick(0, 40, n);
    cycles_to_tick(0, 40, n);
    check("tick0_unchanged", n, 12);

    // Channel 2 held disabled for 20 cycles, then re-enabled.
    ch_en[2] = 1'b0;
    cnt_hi   = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick[2]) cnt_hi++;
    end
    check("dis2_quiet", cnt_hi, 0);
    ch_en[2] = 1'b1;
    nb = 0;
    n  = 0;
    while (!tick[2] && n < 100) begin
      if (base_tick) nb++;
      @(negedge clk);
      n++;
    end
    check("reen2_base_ticks", nb, 3);

    // Channel 3 -> period 5, written exactly on a terminal count.
    cycles_to_tick(3, 40, n);
    repeat (11) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd3;
    cfg_value = 8'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ch3_terminal_tick", tick[3], 1);
    check("ch3_pending",       pending[3], 1);
    cycles_to_tick(3, 60, n);
    check("ch3_old_period", n, 12);
    cycles_to_tick(3, 60, n);
    check("ch3_new_period", n, 24);

    // Randomized traffic, checked by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) ch_en = 4'($urandom) | 4'($urandom);
      cfg_valid = ($urandom_range(3) == 0);
      cfg_chan  = 2'($urandom);
      cfg_value = 8'($urandom_range(3));
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    ch_en     = 4'hF;

    // Reset while an update is outstanding.
    n = 0;
    while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
    check("ready_before_rst", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd0;
    cfg_value = 8'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("wait_apply_pending", pending[0], 1);
    check("wait_apply_ready",   cfg_ready, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check("async_rst_base_tick", base_tick, 0);
    check("async_rst_tick",      tick,      0);
    check("async_rst_pending",   pending,   0);
    check("async_rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick[0] && n < 40);
    check("post_rst_first_tick", n, 13);
    check("post_rst_tick_all", tick, 4'hF);
    cycles_to_tick(0, 40, n);
    check("post_rst_spacing", n, 12);
    repeat (20) @(negedge clk);

    check("scoreboard_activity", (n_popped >= 500), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
